// File: rtl/aes_pkg.sv
// Shared AES helpers: state/word types, GF(2^8) multiply, byte layout.
// Used by both the encryption and decryption datapaths.
package aes_pkg;

    localparam int NB = 4;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } imc_fsm_t;

    function automatic logic [7:0] gf_xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(
        input logic [7:0] x,
        input logic [7:0] c
    );
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = gf_xtime(x);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        unique case (c)
            8'h02:   return x2;
            8'h03:   return x2 ^ x;
            8'h09:   return x8 ^ x;
            8'h0b:   return x8 ^ x2 ^ x;
            8'h0d:   return x8 ^ x4 ^ x;
            8'h0e:   return x8 ^ x4 ^ x2;
            default: return 8'h00;
        endcase
    endfunction

    // MSB bit index of byte (row r, col c): column-major, MSB-first
    function automatic int byte_msb(input int r, input int c);
        return 127 - (c * 32 + r * 8);
    endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// Combinational InvMixColumn of one 32-bit column.
// Row 0 occupies the top byte of the word.
module inv_mix_column_word
    import aes_pkg::*;
(
    input  word_t col,
    output word_t res
);

    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;

    assign a0 = col[31:24];
    assign a1 = col[23:16];
    assign a2 = col[15:8];
    assign a3 = col[7:0];

    assign res[31:24] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                      ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign res[23:16] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                      ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign res[15:8]  = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                      ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign res[7:0]   = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                      ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns engine, one column per clock.
// Define INV_MIX_COLUMNS_PARALLEL_EN for four units and 1-clock latency.
module inv_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int NB = aes_pkg::NB
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    if (NB != 4) begin : g_bad_nb
        $error("inv_mix_columns_seq: NB must be 4");
    end

    imc_fsm_t state_q;
    imc_fsm_t state_d;
    state_t   work;
    state_t   out_q;
    state_t   out_next;
    logic     byp;

`ifdef INV_MIX_COLUMNS_PARALLEL_EN
    state_t mixed;

    for (genvar c = 0; c < 4; c++) begin : g_col
        inv_mix_column_word u_col (
            .col (work[byte_msb(0, c) -: 32]),
            .res (mixed[byte_msb(0, c) -: 32])
        );
    end

    // Whole state transformed in a single BUSY edge
    always_comb begin
        out_next = byp ? work : mixed;
    end
`else
    logic [1:0] col_idx;
    word_t      col_in;
    word_t      col_mix;
    word_t      col_out;

    inv_mix_column_word u_col (
        .col (col_in),
        .res (col_mix)
    );

    // Select the current column and splice its result into the output
    always_comb begin
        col_in   = work[byte_msb(0, 0) -: 32];
        out_next = out_q;
        unique case (col_idx)
            2'd0: col_in = work[byte_msb(0, 0) -: 32];
            2'd1: col_in = work[byte_msb(0, 1) -: 32];
            2'd2: col_in = work[byte_msb(0, 2) -: 32];
            2'd3: col_in = work[byte_msb(0, 3) -: 32];
            default: ;
        endcase
        col_out = byp ? col_in : col_mix;
        unique case (col_idx)
            2'd0: out_next[byte_msb(0, 0) -: 32] = col_out;
            2'd1: out_next[byte_msb(0, 1) -: 32] = col_out;
            2'd2: out_next[byte_msb(0, 2) -: 32] = col_out;
            2'd3: out_next[byte_msb(0, 3) -: 32] = col_out;
            default: ;
        endcase
    end

    // Column counter advances on every BUSY edge and wraps after col 3
    always_ff @(posedge clk) begin
        if (rst) begin
            col_idx <= 2'd0;
        end else if (state_q == IDLE) begin
            col_idx <= 2'd0;
        end else if (state_q == BUSY) begin
            col_idx <= col_idx + 2'd1;
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
`ifdef INV_MIX_COLUMNS_PARALLEL_EN
                state_d = DONE;
`else
                if (col_idx == 2'd3) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Input capture on accept; output register written only while BUSY
    always_ff @(posedge clk) begin
        if (rst) begin
            work  <= '0;
            out_q <= '0;
            byp   <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            work <= in_state;
            byp  <= in_bypass;
        end else if (state_q == BUSY) begin
            out_q <= out_next;
        end
    end

    assign out_state = out_q;

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
- Iterative AES InvMixColumns engine for the decryption datapath. It is the inverse of the encryption-side MixColumns.
- Accepts one 128-bit state over a valid/ready handshake and processes one 32-bit column per clock, reusing one column multiplier.
- Returns the transformed state over a second valid/ready handshake.
- Sits between InvShiftRows/InvSubBytes and AddRoundKey in the decryption round loop. It is also usable for equivalent-inverse-cipher key transformation.

Parameters:
- NB, 4, number of state columns; only 4 is legal, and elaboration fails on any other value.

Ports:
- clk  input  1  single clock; all flops rise-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_state/in_bypass valid.
- in_ready  output  1  engine idle, can accept.
- in_state  input  128  state; byte (row r, col c) at bits [127-(c*32+r*8) -: 8], column-major, MSB-first.
- in_bypass  input  1  1 = pass state through unchanged (last decryption round).
- out_valid  output  1  out_state valid.
- out_ready  input  1  downstream accepts.
- out_state  output  128  transformed state, same byte layout.

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, out_state=0, column index=0, bypass flag=0. Reset is synchronous and active-high; it dominates every other input and aborts any operation in progress, discarding it with no output.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge E0: load in_state into the state register, latch in_bypass, set col_idx=0, go to BUSY.
- BUSY:
  - in_ready=0.
  - At each edge, replace column col_idx of the state register with InvMixColumn(column), or leave it unchanged if bypass is latched. Then increment col_idx.
  - The edge with col_idx==3 goes to DONE, col_idx wraps to 0, and out_valid=1.
  - Columns are processed at edges E1..E4, so out_valid is first high after E4: a fixed latency of 4 clocks, the same for bypass.
- DONE:
  - out_valid=1; out_state = state register, held stable until handshake.
  - On out_valid&out_ready: out_valid=0, go to IDLE, in_ready=1 from the following cycle. There is no same-cycle re-accept.
  - Throughput: 1 state per 6 clocks with out_ready held high.
- in_valid while not in_ready: ignored; the upstream must hold it.
- out_state changes only on the BUSY edges and at reset.
- Column math in GF(2^8) with polynomial 0x11B, where a0..a3 = rows 0..3 of the column:
  - r0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - r1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - r2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - r3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- Multiplies are built from xtime chains: ·09=x8^x, ·0b=x8^x2^x, ·0d=x8^x4^x, ·0e=x8^x4^x2. All results are 8-bit, with no carries.

Optional Feature:
- Macro: INV_MIX_COLUMNS_PARALLEL_EN.
- Defined:
  - Four column units are instantiated, and all columns are transformed at edge E1.
  - BUSY lasts 1 cycle, so out_valid is high after E1 (latency 1 clock). Throughput is 1 state per 3 clocks.
  - col_idx is removed.
- Undefined: the iterative single-unit behaviour above.
- Handshake, bypass and reset semantics are identical in both builds.

Decomposition:
- Shared package aes_pkg:
  - NB=4 constant.
  - state_t (logic [127:0]) and word_t (logic [31:0]) typedefs.
  - Automatic functions gf_xtime and gf_mul(x, const) for 02/03/09/0b/0d/0e, shared with the encryption side.
  - Byte-index helper for the column-major layout.
- Sub-module inv_mix_column_word: purely combinational, 32-bit column in/out, instantiated once (or four times in the parallel build).

Test Plan:
- Reset, then load in_state=8e4da1bc_9fdc589d_01010101_d5d5d7d6, bypass=0, out_ready=1:
  - out_valid high exactly 4 clocks after accept (1 with PARALLEL_EN).
  - out_state=db135345_f20a225c_01010101_d4d4d4d5.
- Same state with in_bypass=1 -> out_state equals the input bit-for-bit, same latency.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid:
  - out_state and out_valid stay stable; in_ready=0 throughout.
  - A second in_valid is not accepted until the cycle after the out handshake.
- Reset asserted mid-BUSY (after E2):
  - The next cycle shows out_valid=0, out_state=0, in_ready=1, and no output for the aborted state.
  - A fresh vector then completes correctly.
- Back-to-back: 20 random states with random in_valid/out_ready gaps:
  - Each output equals the reference model InvMixColumns(input).
  - Chaining the encryption-side MixColumns then this block returns the original state.
